// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - load/shift/unload sequencer for one full-duplex shift register
// Transmits a parallel word MSB-first while capturing serial_in into the same register.
module shift_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             serial_out,
   input  logic             serial_in,
   output logic             shift_en,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      in_ready   = 1'b0;
      shift_en   = 1'b0;
      serial_out = 1'b0;
      out_valid  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shreg_d   = in_data;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            shift_en   = 1'b1;
            serial_out = shreg_q[WIDTH-1];
            shreg_d    = {shreg_q[WIDTH-2:0], serial_in};
            bit_cnt_d  = bit_cnt_q + CW'(1);
            if (bit_cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Reset wins over the decoded outputs so nothing leaks while it is held.
      if (reset) begin
         in_ready   = 1'b0;
         shift_en   = 1'b0;
         serial_out = 1'b0;
         out_valid  = 1'b0;
      end
   end

   assign out_data = reset ? '0 : shreg_q;
   assign busy     = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed table-driven bench for shift_sequencer
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_shift_sequencer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         serial_out;
   logic         serial_in;
   logic         shift_en;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic         busy;

   logic         loop_en;
   logic         si_drv;
   int           checks = 0;
   int           errors = 0;
   time          accept_t;

   assign serial_in = loop_en ? serial_out : si_drv;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .serial_out(serial_out),
      .serial_in (serial_in),
      .shift_en  (shift_en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy)
   );

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] rx;
      bit           loopback;
      logic [W-1:0] exp;
      int           stall;
      bit           noisy;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic transfer(input vec_t v);
      chk("idle_in_ready", in_ready, 1);
      loop_en  = v.loopback;
      in_valid = 1'b1;
      in_data  = v.din;
      step();
      accept_t = $time;
      in_valid = v.noisy;
      for (int i = 0; i < W; i++) begin
         chk("shift_en", shift_en, 1);
         chk("serial_out", serial_out, v.din[W-1-i]);
         chk("shift_out_valid", out_valid, 0);
         chk("shift_in_ready", in_ready, 0);
         chk("shift_busy", busy, 1);
         si_drv = v.rx[W-1-i];
         if (v.noisy) in_data = W'($urandom);
         step();
      end
      in_valid = 1'b0;
      for (int s = 0; s < v.stall; s++) begin
         chk("stall_out_valid", out_valid, 1);
         chk("stall_out_data", out_data, v.exp);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_busy", busy, 1);
         step();
      end
      chk("done_out_valid", out_valid, 1);
      chk("done_out_data", out_data, v.exp);
      chk("done_shift_en", shift_en, 0);
      chk("done_serial_out", serial_out, 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("after_in_ready", in_ready, 1);
      chk("after_out_valid", out_valid, 0);
      chk("after_busy", busy, 0);
   endtask

   initial begin
      vec_t  v;
      time   prev_t;
      logic [W-1:0] w;

      vecs[0] = '{din: 8'hA5, rx: 8'h00, loopback: 1, exp: 8'hA5, stall: 0, noisy: 0};
      vecs[1] = '{din: 8'h00, rx: 8'hFF, loopback: 0, exp: 8'hFF, stall: 0, noisy: 0};
      vecs[2] = '{din: 8'h81, rx: 8'h5A, loopback: 0, exp: 8'h5A, stall: 5, noisy: 0};
      vecs[3] = '{din: 8'hC3, rx: 8'h00, loopback: 1, exp: 8'hC3, stall: 0, noisy: 1};
      vecs[4] = '{din: 8'hFF, rx: 8'h00, loopback: 0, exp: 8'h00, stall: 1, noisy: 0};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      loop_en   = 1'b0;
      si_drv    = 1'b0;
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_shift_en", shift_en, 0);
      chk("rst_serial_out", serial_out, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      step();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_busy", busy, 0);

      for (int k = 0; k < 5; k++) transfer(vecs[k]);

      // Reset pulse after three shift cycles aborts the word.
      loop_en  = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'hE7;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("mid_shift_en", shift_en, 1);
      reset = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_shift_en", shift_en, 0);
      step();
      reset = 1'b0;
      #1;
      chk("abort_shift_en", shift_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_serial_out", serial_out, 0);
      chk("abort_in_ready", in_ready, 1);
      v = '{din: 8'h3C, rx: 8'h00, loopback: 1, exp: 8'h3C, stall: 0, noisy: 0};
      transfer(v);

      // Random loopback words with random stalls; back-to-back period check.
      prev_t = 0;
      for (int n = 0; n < 10; n++) begin
         w = W'($urandom);
         v = '{din: w, rx: 8'h00, loopback: 1, exp: w, stall: int'($urandom_range(0, 3)), noisy: 0};
         transfer(v);
         if (n > 0) chk("period_ge_10", (accept_t - prev_t) >= 100, 1);
         prev_t = accept_t;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
